multadd_vec_checker: RTL and testbench

Hardware stimulus/response engine for the 10-bit multiply-add datapath. It reads packed test vectors from an external synchronous vector ROM and drives `x1`/`x2`/`x3` into the datapath. After a fixed settle interval it samples the datapath's `y` and compares it against the expected result, counting mismatches. It is the on-chip equivalent of the file-driven bench: it checks the datapath on the board, with results shown on LEDs and seven-segment displays.

---
 rtl/multadd_vec_checker_pkg.sv | 27 ++
 rtl/multadd_vec_checker_if.sv | 25 ++
 rtl/multadd_vec_checker.sv | 132 +++++++++++++
 tb/tb_multadd_vec_checker.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/multadd_vec_checker_pkg.sv
// Shared definitions for the multiply-add vector checker: vector field layout,
// data widths and the sequencer state encoding.
package multadd_pkg;

    localparam int DW    = 10;
    localparam int VEC_W = 40;

    // Packed vector layout as stored in the vector ROM
    localparam int X1_HI  = 39;
    localparam int X1_LO  = 30;
    localparam int X2_HI  = 29;
    localparam int X2_LO  = 20;
    localparam int X3_HI  = 19;
    localparam int X3_LO  = 10;
    localparam int EXP_HI = 9;
    localparam int EXP_LO = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

endpackage

// File: rtl/multadd_vec_checker_if.sv
// Vector-ROM and datapath connections of the checker. The checker is the master:
// it drives the ROM address and the operands, and receives ROM data and y.
interface multadd_vec_checker_if #(
    parameter int AW = 4
);
    import multadd_pkg::*;

    logic [AW-1:0]    rom_addr;
    logic [VEC_W-1:0] rom_data;
    logic [DW-1:0]    x1;
    logic [DW-1:0]    x2;
    logic [DW-1:0]    x3;
    logic [DW-1:0]    y;

    modport master (
        output rom_addr, x1, x2, x3,
        input  rom_data, y
    );

    modport slave (
        input  rom_addr, x1, x2, x3,
        output rom_data, y
    );

endinterface

// File: rtl/multadd_vec_checker.sv
// On-chip stimulus/response engine: steps through NUM_VEC ROM vectors, drives the
// multiply-add datapath, samples y after SETTLE cycles and counts mismatches.
module multadd_vec_checker
    import multadd_pkg::*;
#(
    parameter int NUM_VEC = 16,
    parameter int SETTLE  = 4,
    parameter int ERR_W   = 8,
    parameter int AW      = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    multadd_vec_checker_if.master   vif,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [ERR_W-1:0]        err_count,
    output logic                    fail_valid,
    output logic [AW-1:0]           fail_idx
);

    localparam int CW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [CW-1:0]    CNT_LAST = CW'(SETTLE - 1);
    localparam logic [AW-1:0]    IDX_LAST = AW'(NUM_VEC - 1);
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    state_t           state_q, state_d;
    logic [AW-1:0]    idx;
    logic [CW-1:0]    cnt;
    logic [DW-1:0]    exp_y;
    logic             run_clr;
    logic             do_check;
    logic             mismatch;
    logic             last_vec;
    logic [ERR_W-1:0] err_next;

    assign vif.rom_addr = idx;

    assign mismatch = (vif.y != exp_y);
    assign last_vec = (idx == IDX_LAST);

    // Count of mismatches including the one being decided this cycle
    always_comb begin
        err_next = err_count;
        if (mismatch && (err_count != ERR_MAX))
            err_next = err_count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        run_clr  = 1'b0;
        do_check = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_FETCH;
                    run_clr = 1'b1;
                end
            end
            S_FETCH:  state_d = S_LOAD;
            S_LOAD:   state_d = S_SETTLE;
            S_SETTLE: if (cnt == CNT_LAST) state_d = S_CHECK;
            S_CHECK: begin
                do_check = 1'b1;
                state_d  = last_vec ? S_DONE : S_FETCH;
            end
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            cnt        <= '0;
            exp_y      <= '0;
            vif.x1     <= '0;
            vif.x2     <= '0;
            vif.x3     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_idx   <= '0;
        end else begin
            fail_valid <= 1'b0;

            if (run_clr) begin
                idx       <= '0;
                err_count <= '0;
                done      <= 1'b0;
                pass      <= 1'b0;
                fail_idx  <= '0;
                busy      <= 1'b1;
            end

            // Operands only change here, so they hold across the next FETCH
            if (state_q == S_LOAD) begin
                vif.x1 <= vif.rom_data[X1_HI:X1_LO];
                vif.x2 <= vif.rom_data[X2_HI:X2_LO];
                vif.x3 <= vif.rom_data[X3_HI:X3_LO];
                exp_y  <= vif.rom_data[EXP_HI:EXP_LO];
                cnt    <= '0;
            end

            if (state_q == S_SETTLE)
                cnt <= cnt + 1'b1;

            if (do_check) begin
                if (mismatch) begin
                    fail_valid <= 1'b1;
                    fail_idx   <= idx;
                    err_count  <= err_next;
                end
                if (last_vec) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    pass <= (err_next == '0);
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_multadd_vec_checker.sv
// Directed bench for multadd_vec_checker: four checker instances share one clock,
// fed by bench ROMs and behavioural multiply-add stubs (immediate and delayed y).
module tb_multadd_vec_checker;
    import multadd_pkg::*;

    logic clk;
    logic reset;
    logic start_a;
    logic start_o;

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] x1;
        logic [9:0] x2;
        logic [9:0] x3;
        logic [9:0] ey;
    } vec_t;

    // Hand-computed y = (x1*x2 + x3) mod 1024
    vec_t vecs [4];
    initial begin
        vecs[0] = '{10'd3,    10'd5,    10'd7,  10'h016};
        vecs[1] = '{10'd10,   10'd20,   10'd30, 10'h0E6};
        vecs[2] = '{10'd2,    10'd8,    10'd6,  10'h016};
        vecs[3] = '{10'd1023, 10'd1023, 10'd1,  10'h002};
    end

    function automatic logic [9:0] dp(input logic [9:0] a, input logic [9:0] b, input logic [9:0] c);
        logic [19:0] t;
        t = a * b + {10'd0, c};
        return t[9:0];
    endfunction

    // ---------------- instance A: ERR_W=8, SETTLE=4, immediate stub
    multadd_vec_checker_if #(.AW(2)) if_a ();
    logic [39:0] rom_a [4];
    logic busy_a, done_a, pass_a, fv_a;
    logic [7:0] err_a;
    logic [1:0] fidx_a;
    always @(posedge clk) if_a.rom_data <= rom_a[if_a.rom_addr];
    assign if_a.y = dp(if_a.x1, if_a.x2, if_a.x3);
    multadd_vec_checker #(.NUM_VEC(4), .SETTLE(4), .ERR_W(8), .AW(2)) u_a (
        .clk(clk), .reset(reset), .start(start_a), .vif(if_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .fail_valid(fv_a), .fail_idx(fidx_a)
    );

    // ---------------- instance B: ERR_W=2, all expected values wrong
    multadd_vec_checker_if #(.AW(2)) if_b ();
    logic [39:0] rom_b [4];
    logic busy_b, done_b, pass_b, fv_b;
    logic [1:0] err_b;
    logic [1:0] fidx_b;
    always @(posedge clk) if_b.rom_data <= rom_b[if_b.rom_addr];
    assign if_b.y = dp(if_b.x1, if_b.x2, if_b.x3);
    multadd_vec_checker #(.NUM_VEC(4), .SETTLE(4), .ERR_W(2), .AW(2)) u_b (
        .clk(clk), .reset(reset), .start(start_o), .vif(if_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .fail_valid(fv_b), .fail_idx(fidx_b)
    );

    // ---------------- instances C (SETTLE=4) and D (SETTLE=3): y lags x by 4 cycles
    logic [39:0] rom_g [4];
    multadd_vec_checker_if #(.AW(2)) if_c ();
    multadd_vec_checker_if #(.AW(2)) if_d ();
    logic [9:0] dly_c [4];
    logic [9:0] dly_d [4];
    initial for (int i = 0; i < 4; i++) begin dly_c[i] = '0; dly_d[i] = '0; end
    always @(posedge clk) begin
        if_c.rom_data <= rom_g[if_c.rom_addr];
        if_d.rom_data <= rom_g[if_d.rom_addr];
        dly_c[0] <= dp(if_c.x1, if_c.x2, if_c.x3);
        dly_d[0] <= dp(if_d.x1, if_d.x2, if_d.x3);
        for (int i = 1; i < 4; i++) begin
            dly_c[i] <= dly_c[i-1];
            dly_d[i] <= dly_d[i-1];
        end
    end
    assign if_c.y = dly_c[3];
    assign if_d.y = dly_d[3];

    logic busy_c, done_c, pass_c, fv_c, busy_d, done_d, pass_d, fv_d;
    logic [7:0] err_c, err_d;
    logic [1:0] fidx_c, fidx_d;
    multadd_vec_checker #(.NUM_VEC(4), .SETTLE(4), .ERR_W(8), .AW(2)) u_c (
        .clk(clk), .reset(reset), .start(start_o), .vif(if_c),
        .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
        .fail_valid(fv_c), .fail_idx(fidx_c)
    );
    multadd_vec_checker #(.NUM_VEC(4), .SETTLE(3), .ERR_W(8), .AW(2)) u_d (
        .clk(clk), .reset(reset), .start(start_o), .vif(if_d),
        .busy(busy_d), .done(done_d), .pass(pass_d), .err_count(err_d),
        .fail_valid(fv_d), .fail_idx(fidx_d)
    );

    // ---------------- helpers
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic load_a(input logic [3:0] mask);
        for (int i = 0; i < 4; i++)
            rom_a[i] = {vecs[i].x1, vecs[i].x2, vecs[i].x3,
                        mask[i] ? 10'(vecs[i].ey + 10'd1) : vecs[i].ey};
    endtask

    // Edges are counted from the one that samples start (edge 1);
    // done is expected first after edge 29 = 4*(4+3)+1.
    task automatic run_a(input int restart_at, output int edges, output int pulses);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        edges  = 1;
        pulses = 0;
        chk("start_busy", busy_a, 1);
        chk("start_done_clr", done_a, 0);
        chk("start_err_clr", err_a, 0);
        chk("start_rom_addr", if_a.rom_addr, 0);
        while (!done_a && edges < 100) begin
            if (edges == restart_at) start_a = 1'b1;
            tick();
            start_a = 1'b0;
            edges++;
            if (fv_a) pulses++;
        end
    endtask

    typedef struct {
        logic [3:0] mask;
        int         exp_err;
        logic       exp_pass;
        int         exp_idx;
        int         exp_pulses;
        int         restart_at;
    } scen_t;

    scen_t scen [4];

    initial begin
        int edges, pulses, pulses_b;

        scen[0] = '{4'b0000, 0, 1'b1, 0, 0, -1};
        scen[1] = '{4'b0100, 1, 1'b0, 2, 1, -1};
        scen[2] = '{4'b1001, 2, 1'b0, 3, 2, 12};
        scen[3] = '{4'b1111, 4, 1'b0, 3, 4, -1};

        for (int i = 0; i < 4; i++) begin
            rom_b[i] = {vecs[i].x1, vecs[i].x2, vecs[i].x3, 10'(vecs[i].ey + 10'd5)};
            rom_g[i] = {vecs[i].x1, vecs[i].x2, vecs[i].x3, vecs[i].ey};
        end
        load_a(4'b0000);

        start_a = 1'b0;
        start_o = 1'b0;
        reset   = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        chk("rst_pass", pass_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_fv", fv_a, 0);
        chk("rst_x1", if_a.x1, 0);
        chk("rst_rom_addr", if_a.rom_addr, 0);

        // Table of runs on instance A, each restarting from DONE
        for (int s = 0; s < 4; s++) begin
            load_a(scen[s].mask);
            run_a(scen[s].restart_at, edges, pulses);
            chk($sformatf("s%0d_latency", s), edges, 29);
            chk($sformatf("s%0d_done", s), done_a, 1);
            chk($sformatf("s%0d_busy", s), busy_a, 0);
            chk($sformatf("s%0d_err", s), err_a, scen[s].exp_err);
            chk($sformatf("s%0d_pass", s), pass_a, scen[s].exp_pass);
            chk($sformatf("s%0d_fidx", s), fidx_a, scen[s].exp_idx);
            chk($sformatf("s%0d_pulses", s), pulses, scen[s].exp_pulses);
            chk($sformatf("s%0d_x1_hold", s), if_a.x1, vecs[3].x1);
            chk($sformatf("s%0d_x3_hold", s), if_a.x3, vecs[3].x3);
        end

        // Reset during SETTLE of vector 1, with start high at the same time
        load_a(4'b0001);
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int e = 1; e < 11; e++) tick();
        chk("mid_err_before_rst", err_a, 1);
        chk("mid_x1_vec1", if_a.x1, vecs[1].x1);
        reset   = 1'b1;
        start_a = 1'b1;
        tick();
        reset   = 1'b0;
        start_a = 1'b0;
        chk("mrst_busy", busy_a, 0);
        chk("mrst_done", done_a, 0);
        chk("mrst_err", err_a, 0);
        chk("mrst_fidx", fidx_a, 0);
        chk("mrst_x1", if_a.x1, 0);
        chk("mrst_x2", if_a.x2, 0);
        chk("mrst_rom_addr", if_a.rom_addr, 0);
        tick();
        chk("mrst_idle", busy_a, 0);
        load_a(4'b0000);
        run_a(-1, edges, pulses);
        chk("post_rst_latency", edges, 29);
        chk("post_rst_pass", pass_a, 1);
        chk("post_rst_err", err_a, 0);

        // Saturation and settle-time runs on B, C, D together
        start_o = 1'b1;
        tick();
        start_o = 1'b0;
        edges    = 1;
        pulses_b = 0;
        while (!(done_b && done_c && done_d) && edges < 100) begin
            tick();
            edges++;
            if (fv_b) pulses_b++;
        end
        chk("bcd_timeout", edges, 29);
        chk("b_done", done_b, 1);
        chk("b_err_sat", err_b, 3);
        chk("b_pass", pass_b, 0);
        chk("b_pulses", pulses_b, 4);
        chk("c_pass", pass_c, 1);
        chk("c_err", err_c, 0);
        chk("d_done", done_d, 1);
        chk("d_err", err_d, 4);
        chk("d_pass", pass_d, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
